graphics_processor: RTL and testbench

//   Executor side of the gp_* paint-command interface driven by game_controller.

---
 rtl/graphics_processor.sv | 150 +++++++++++++++
 tb/tb_graphics_processor.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/graphics_processor.sv
// graphics_processor: paint-command executor for the 640x480 RGB444 frame buffer.
// Latches one rectangle command (solid fill or 1-pixel outline), scans its box
// row-major at one coordinate per clock onto the VRAM write port, then holds
// gp_finish until the requester drops gp_en.
// Optional build macro GP_CLIP_EN: clamps the bottom-right corner to the visible
// area at latch time and skips the scan entirely for an empty box.
module graphics_processor #(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int COLOR_W = 12,
    parameter int ADDR_W  = 19,
    localparam int X_W    = $clog2(H_RES),
    localparam int Y_W    = $clog2(V_RES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               gp_en,
    input  logic               gp_opcode,
    input  logic [X_W-1:0]     gp_tl_x,
    input  logic [Y_W-1:0]     gp_tl_y,
    input  logic [X_W-1:0]     gp_br_x,
    input  logic [Y_W-1:0]     gp_br_y,
    input  logic [COLOR_W-1:0] gp_arg,
    output logic               gp_finish,
    output logic               vram_we,
    output logic [ADDR_W-1:0]  vram_addr,
    output logic [COLOR_W-1:0] vram_data
);

    typedef enum logic [1:0] {ST_IDLE, ST_DRAW, ST_DONE} state_t;

    state_t             r_state;
    logic               r_op;
    logic [X_W-1:0]     r_tl_x;
    logic [X_W-1:0]     r_br_x;
    logic [X_W-1:0]     r_x;
    logic [Y_W-1:0]     r_tl_y;
    logic [Y_W-1:0]     r_br_y;
    logic [Y_W-1:0]     r_y;
    logic [COLOR_W-1:0] r_arg;

    logic               w_last;
    logic               w_edge;
    logic [ADDR_W-1:0]  w_addr;

    // Scan-position decode: final coordinate, outline membership, linear address.
    // The row pitch of 640 is built as y*512 + y*128 so no multiplier is needed.
    assign w_last = (r_x == r_br_x) && (r_y == r_br_y);
    assign w_edge = (r_x == r_tl_x) || (r_x == r_br_x) ||
                    (r_y == r_tl_y) || (r_y == r_br_y);
    assign w_addr = (ADDR_W'(r_y) << 9) + (ADDR_W'(r_y) << 7) + ADDR_W'(r_x);

`ifdef GP_CLIP_EN
    logic [X_W-1:0] w_clip_br_x;
    logic [Y_W-1:0] w_clip_br_y;
    logic           w_clip_empty;

    // Clamp the requested bottom-right corner to the last visible pixel.
    assign w_clip_br_x  = (gp_br_x > X_W'(H_RES - 1)) ? X_W'(H_RES - 1) : gp_br_x;
    assign w_clip_br_y  = (gp_br_y > Y_W'(V_RES - 1)) ? Y_W'(V_RES - 1) : gp_br_y;
    assign w_clip_empty = (gp_tl_x > w_clip_br_x) || (gp_tl_y > w_clip_br_y);
`endif

    // Command FSM with registered VRAM port and handshake outputs.
    // NOTE: non-blocking assignments everywhere here, so every output is a true
    // flop and all branches see the pre-edge values of r_x/r_y together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_op      <= 1'b0;
            r_tl_x    <= '0;
            r_br_x    <= '0;
            r_x       <= '0;
            r_tl_y    <= '0;
            r_br_y    <= '0;
            r_y       <= '0;
            r_arg     <= '0;
            gp_finish <= 1'b0;
            vram_we   <= 1'b0;
            vram_addr <= '0;
            vram_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    gp_finish <= 1'b0;
                    vram_we   <= 1'b0;
                    vram_addr <= '0;
                    vram_data <= '0;
                    if (gp_en) begin
                        r_op   <= gp_opcode;
                        r_tl_x <= gp_tl_x;
                        r_tl_y <= gp_tl_y;
                        r_x    <= gp_tl_x;
                        r_y    <= gp_tl_y;
                        r_arg  <= gp_arg;
`ifdef GP_CLIP_EN
                        r_br_x  <= w_clip_br_x;
                        r_br_y  <= w_clip_br_y;
                        r_state <= w_clip_empty ? ST_DONE : ST_DRAW;
`else
                        r_br_x  <= gp_br_x;
                        r_br_y  <= gp_br_y;
                        r_state <= ST_DRAW;
`endif
                    end
                end

                ST_DRAW: begin
                    if (!gp_en) begin
                        // Requester withdrew: drop the command without finishing.
                        r_state   <= ST_IDLE;
                        vram_we   <= 1'b0;
                        vram_addr <= '0;
                        vram_data <= '0;
                    end else begin
                        // Outline mode still spends a cycle on interior pixels.
                        vram_we   <= !r_op || w_edge;
                        vram_addr <= w_addr;
                        vram_data <= r_arg;
                        if (w_last) begin
                            r_state <= ST_DONE;
                        end else if (r_x == r_br_x) begin
                            r_x <= r_tl_x;
                            r_y <= r_y + 1'b1;
                        end else begin
                            r_x <= r_x + 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    vram_we   <= 1'b0;
                    vram_addr <= '0;
                    vram_data <= '0;
                    if (gp_en) begin
                        gp_finish <= 1'b1;
                    end else begin
                        gp_finish <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_graphics_processor.sv
// tb_graphics_processor: directed bench for graphics_processor.
// A box-level model lists every pixel address a command must write, in order;
// one compare process matches each DUT write against that list, and the command
// task checks handshake timing. Clip-mode cases run when GP_CLIP_EN is defined.
module tb_graphics_processor;

    logic        clk;
    logic        rst;
    logic        gp_en;
    logic        gp_opcode;
    logic [9:0]  gp_tl_x;
    logic [8:0]  gp_tl_y;
    logic [9:0]  gp_br_x;
    logic [8:0]  gp_br_y;
    logic [11:0] gp_arg;
    logic        gp_finish;
    logic        vram_we;
    logic [18:0] vram_addr;
    logic [11:0] vram_data;

    graphics_processor dut (
        .clk       (clk),
        .rst       (rst),
        .gp_en     (gp_en),
        .gp_opcode (gp_opcode),
        .gp_tl_x   (gp_tl_x),
        .gp_tl_y   (gp_tl_y),
        .gp_br_x   (gp_br_x),
        .gp_br_y   (gp_br_y),
        .gp_arg    (gp_arg),
        .gp_finish (gp_finish),
        .vram_we   (vram_we),
        .vram_addr (vram_addr),
        .vram_data (vram_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          exp_q[$];
    logic [11:0] exp_data = '0;
    int          wr_count = 0;
    int          first_we_cyc = -1;
    int          last_we_cyc = -1;
    int          last_addr = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Advance to a point safely between active edges.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Every pixel address a command must write, in row-major order.
    task automatic model_box(input logic op, input int tlx, input int tly, input int brx,
                             input int bry, output int q[$]);
        int bx;
        int by;
        bx = brx;
        by = bry;
`ifdef GP_CLIP_EN
        if (bx > 639) bx = 639;
        if (by > 479) by = 479;
`endif
        q.delete();
        for (int y = tly; y <= by; y++)
            for (int x = tlx; x <= bx; x++)
                if (op == 1'b0 || x == tlx || x == bx || y == tly || y == by)
                    q.push_back((y * 640 + x) % (1 << 19));
    endtask

    // Compare process: every DUT write must be the next pixel the model expects.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (!rst && vram_we === 1'b1) begin
                wr_count++;
                last_we_cyc = cyc;
                last_addr   = int'(vram_addr);
                if (first_we_cyc < 0) first_we_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0d written, none expected", vram_addr);
                end else begin
                    e = exp_q.pop_front();
                    check("vram_addr", 32'(vram_addr), e);
                    check("vram_data", 32'(vram_data), 32'(exp_data));
                end
            end
        end
    end

    // Issue one command, follow it to gp_finish, optionally hold in DONE, release.
    task automatic run_cmd(input string tag, input logic op, input int tlx, input int tly,
                           input int brx, input int bry, input logic [11:0] arg, input int hold);
        int q[$];
        int n_exp;
        int k;
        int fin;
        int cells;
        int bx;
        int by;
        bit seen;
        bx = brx;
        by = bry;
`ifdef GP_CLIP_EN
        if (bx > 639) bx = 639;
        if (by > 479) by = 479;
`endif
        cells = (bx >= tlx && by >= tly) ? (bx - tlx + 1) * (by - tly + 1) : 0;
        model_box(op, tlx, tly, brx, bry, q);
        n_exp        = q.size();
        exp_q        = q;
        exp_data     = arg;
        wr_count     = 0;
        first_we_cyc = -1;
        last_we_cyc  = -1;

        step();
        gp_opcode = op;
        gp_tl_x   = 10'(tlx);
        gp_tl_y   = 9'(tly);
        gp_br_x   = 10'(brx);
        gp_br_y   = 9'(bry);
        gp_arg    = arg;
        gp_en     = 1'b1;
        k         = cyc;

        // Disturb every command input once the command is latched.
        step();
        gp_opcode = ~op;
        gp_tl_x   = 10'($urandom_range(0, 1023));
        gp_tl_y   = 9'($urandom_range(0, 511));
        gp_br_x   = 10'($urandom_range(0, 1023));
        gp_br_y   = 9'($urandom_range(0, 511));
        gp_arg    = ~arg;

        seen = 1'b0;
        fin  = 0;
        for (int i = 0; i < cells + 20 && !seen; i++) begin
            step();
            if (gp_finish === 1'b1) begin
                seen = 1'b1;
                fin  = cyc;
            end
        end
        check({tag, "_finish_seen"}, 32'(seen), 1);
        if (seen) begin
            if (n_exp > 0) begin
                check({tag, "_first_write_cycle"}, first_we_cyc - k, 2);
                check({tag, "_finish_after_last"}, fin - last_we_cyc, 1);
                check({tag, "_scan_cycles"}, last_we_cyc - first_we_cyc + 1, cells);
            end else begin
                check({tag, "_finish_within_2"}, 32'(fin - k <= 2), 1);
            end
        end
        check({tag, "_write_count"}, wr_count, n_exp);
        check({tag, "_model_drained"}, exp_q.size(), 0);

        for (int i = 0; i < hold; i++) begin
            step();
            check({tag, "_hold_finish"}, 32'(gp_finish), 1);
            check({tag, "_hold_we"}, 32'(vram_we), 0);
        end
        if (hold > 0) check({tag, "_hold_no_relaunch"}, wr_count, n_exp);

        gp_en = 1'b0;
        step();
        check({tag, "_finish_drop"}, 32'(gp_finish), 0);
        check({tag, "_idle_we"}, 32'(vram_we), 0);
        exp_q.delete();
    endtask

    initial begin
        int mq[$];
        int n641;
        bit got;
        rst       = 1'b1;
        gp_en     = 1'b0;
        gp_opcode = 1'b0;
        gp_tl_x   = '0;
        gp_tl_y   = '0;
        gp_br_x   = '0;
        gp_br_y   = '0;
        gp_arg    = '0;
        repeat (3) step();
        check("rst_finish", 32'(gp_finish), 0);
        check("rst_we", 32'(vram_we), 0);
        check("rst_addr", 32'(vram_addr), 0);
        check("rst_data", 32'(vram_data), 0);
        rst = 1'b0;
        step();

        // 1: 2x2 fill; pin the model against hand-computed addresses.
        model_box(1'b0, 10, 5, 11, 6, mq);
        check("m1_size", mq.size(), 4);
        check("m1_a0", mq[0], 3210);
        check("m1_a1", mq[1], 3211);
        check("m1_a2", mq[2], 3850);
        check("m1_a3", mq[3], 3851);
        run_cmd("t1", 1'b0, 10, 5, 11, 6, 12'hABC, 0);

        // 2: 3x3 outline: centre pixel 641 skipped, 9 cycles spent.
        model_box(1'b1, 0, 0, 2, 2, mq);
        n641 = 0;
        foreach (mq[i]) if (mq[i] == 641) n641++;
        check("m2_size", mq.size(), 8);
        check("m2_no_641", n641, 0);
        run_cmd("t2", 1'b1, 0, 0, 2, 2, 12'hF00, 0);

        // 3: single-pixel boxes, wide outline degenerates to fill, bottom band of screen.
        model_box(1'b0, 639, 479, 639, 479, mq);
        check("m3_size", mq.size(), 1);
        check("m3_addr", mq[0], 307199);
        run_cmd("t3a", 1'b0, 639, 479, 639, 479, 12'h123, 0);
        check("t3a_last_addr", last_addr, 307199);
        run_cmd("t3b", 1'b1, 7, 7, 7, 7, 12'h456, 0);
        run_cmd("t3c", 1'b1, 100, 50, 119, 50, 12'h789, 0);
        model_box(1'b0, 0, 470, 639, 479, mq);
        check("m3d_size", mq.size(), 6400);
        check("m3d_last", mq[mq.size() - 1], 307199);
        run_cmd("t3d", 1'b0, 0, 470, 639, 479, 12'h0F0, 0);
        check("t3d_last_addr", last_addr, 307199);

        // 6: hold gp_en in DONE for 20 cycles.
        run_cmd("t6", 1'b1, 300, 200, 304, 203, 12'h5A5, 20);

        // 4a: abort a 10x10 fill after 3 writes.
        model_box(1'b0, 100, 100, 109, 109, mq);
        exp_q        = mq;
        exp_data     = 12'h3C3;
        wr_count     = 0;
        first_we_cyc = -1;
        step();
        gp_opcode = 1'b0;
        gp_tl_x   = 10'd100;
        gp_tl_y   = 9'd100;
        gp_br_x   = 10'd109;
        gp_br_y   = 9'd109;
        gp_arg    = 12'h3C3;
        gp_en     = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            step();
            if (wr_count >= 3) got = 1'b1;
        end
        check("t4a_reached_3", 32'(got), 1);
        gp_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t4a_we_after_abort", 32'(vram_we), 0);
            check("t4a_finish_after_abort", 32'(gp_finish), 0);
        end
        check("t4a_write_count", wr_count, 3);
        exp_q.delete();
        run_cmd("t4a_relaunch", 1'b0, 20, 30, 22, 30, 12'h111, 0);

        // 4b: reset in the middle of a scan.
        model_box(1'b0, 200, 200, 209, 209, mq);
        exp_q    = mq;
        exp_data = 12'hE1E;
        wr_count = 0;
        step();
        gp_tl_x = 10'd200;
        gp_tl_y = 9'd200;
        gp_br_x = 10'd209;
        gp_br_y = 9'd209;
        gp_arg  = 12'hE1E;
        gp_en   = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            step();
            if (wr_count >= 2) got = 1'b1;
        end
        check("t4b_reached_2", 32'(got), 1);
        rst = 1'b1;
        step();
        check("t4b_rst_we", 32'(vram_we), 0);
        check("t4b_rst_addr", 32'(vram_addr), 0);
        check("t4b_rst_data", 32'(vram_data), 0);
        check("t4b_rst_finish", 32'(gp_finish), 0);
        gp_en = 1'b0;
        step();
        rst = 1'b0;
        exp_q.delete();
        step();
        check("t4b_idle_we", 32'(vram_we), 0);
        check("t4b_idle_finish", 32'(gp_finish), 0);
        run_cmd("t4b_relaunch", 1'b1, 50, 60, 53, 62, 12'h222, 0);

`ifdef GP_CLIP_EN
        // 5: clipped right edge, and a box entirely off-screen.
        model_box(1'b0, 630, 479, 700, 479, mq);
        check("m5a_size", mq.size(), 10);
        check("m5a_last", mq[mq.size() - 1], 307199);
        run_cmd("t5a", 1'b0, 630, 479, 700, 479, 12'h777, 0);
        check("t5a_last_addr", last_addr, 307199);
        run_cmd("t5b", 1'b0, 650, 0, 700, 0, 12'h888, 0);
`endif

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
